// File: rtl/odd_parity_frame_checker_if.sv
// Bundle that connects an odd-parity frame checker to the logic around it.
// The bit-timing side drives bit_en/rx; the consuming datapath reads the
// frame result, the status flags and the error count.
interface odd_parity_frame_checker_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
);
    logic              bit_en;
    logic              rx;
    logic [DATA_W-1:0] data_out;
    logic              valid;
    logic              parity_err;
    logic              frame_err;
    logic              busy;
    logic [CNT_W-1:0]  err_count;

    // Bit-timing / line side: supplies strobes and serial data, reads results.
    modport master (
        output bit_en, rx,
        input  data_out, valid, parity_err, frame_err, busy, err_count
    );

    // Checker side.
    modport slave (
        input  bit_en, rx,
        output data_out, valid, parity_err, frame_err, busy, err_count
    );
endinterface

// File: rtl/odd_parity_frame_checker.sv
// Receive-side deserialiser and checker for odd-parity serial frames:
// start bit (0), DATA_W data bits LSB first, parity bit, stop bit (1).
// Every state change is qualified by the bit_en sample strobe; only the
// one-cycle valid pulse clears without a strobe.
module odd_parity_frame_checker #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input logic                     clk,
    input logic                     rst,
    odd_parity_frame_checker_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    localparam int                 BIT_CNT_W = $clog2(DATA_W + 1);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT  = BIT_CNT_W'(DATA_W - 1);

    state_t               state;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic [DATA_W-1:0]    shift_reg;
    logic                 parity_bit;

    logic [DATA_W-1:0]    data_q;
    logic                 valid_q;
    logic                 parity_err_q;
    logic                 frame_err_q;
    logic                 busy_q;
    logic [CNT_W-1:0]     err_count_q;

    logic [DATA_W-1:0]    shift_next;
    logic                 parity_bad;
    logic                 stop_bad;

    // Next shift value (new bit enters at the MSB) and frame verdicts.
    // NOTE: every signal assigned in a combinational block gets a value on
    // every path, otherwise synthesis infers a latch.
    always_comb begin
        shift_next = (shift_reg >> 1) | (DATA_W'(bus.rx) << (DATA_W - 1));
        // Odd parity is met when data ones plus the parity bit is odd.
        parity_bad = ~(^shift_reg ^ parity_bit);
        stop_bad   = ~bus.rx;
    end

    // Frame FSM with registered outputs.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values and simulation matches the synthesised flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            shift_reg    <= '0;
            parity_bit   <= 1'b0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
            err_count_q  <= '0;
        end else begin
            valid_q <= 1'b0;
            if (bus.bit_en) begin
                unique case (state)
                    IDLE: begin
                        if (!bus.rx) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                            busy_q  <= 1'b1;
                        end
                    end
                    DATA: begin
                        shift_reg <= shift_next;
                        bit_cnt   <= bit_cnt + BIT_CNT_W'(1);
                        if (bit_cnt == LAST_BIT) begin
                            state <= PARITY;
                        end
                    end
                    PARITY: begin
                        parity_bit <= bus.rx;
                        state      <= STOP;
                    end
                    STOP: begin
                        data_q       <= shift_reg;
                        parity_err_q <= parity_bad;
                        frame_err_q  <= stop_bad;
                        valid_q      <= 1'b1;
                        busy_q       <= 1'b0;
                        state        <= IDLE;
                        // A frame counts once even with both errors; the
                        // counter holds at all-ones.
                        if ((parity_bad || stop_bad) && (err_count_q != '1)) begin
                            err_count_q <= err_count_q + CNT_W'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.data_out   = data_q;
    assign bus.valid      = valid_q;
    assign bus.parity_err = parity_err_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.busy       = busy_q;
    assign bus.err_count  = err_count_q;
endmodule

// File: tb/tb_odd_parity_frame_checker.sv
// Self-checking bench for odd_parity_frame_checker. Two instances share one
// line: an 8-bit counter build and a 2-bit counter build (saturation).
// A frame-level model collects strobed bits in a queue and evaluates each
// complete frame arithmetically; a compare process checks every cycle.
module tb_odd_parity_frame_checker;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst;
    logic bit_en = 1'b0;
    logic rx     = 1'b1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    odd_parity_frame_checker_if #(.DATA_W(DW), .CNT_W(8)) bus_a ();
    odd_parity_frame_checker_if #(.DATA_W(DW), .CNT_W(2)) bus_b ();

    assign bus_a.bit_en = bit_en;
    assign bus_a.rx     = rx;
    assign bus_b.bit_en = bit_en;
    assign bus_b.rx     = rx;

    odd_parity_frame_checker #(.DATA_W(DW), .CNT_W(8)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    odd_parity_frame_checker #(.DATA_W(DW), .CNT_W(2)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit        q[$];
    logic [DW-1:0] m_data = '0;
    bit        m_valid = 1'b0;
    bit        m_perr  = 1'b0;
    bit        m_ferr  = 1'b0;
    int        m_cnt_a = 0;
    int        m_cnt_b = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_data  = '0;
            m_valid = 1'b0;
            m_perr  = 1'b0;
            m_ferr  = 1'b0;
            m_cnt_a = 0;
            m_cnt_b = 0;
        end else begin
            m_valid = 1'b0;
            if (bit_en === 1'b1) begin
                if (q.size() != 0 || rx === 1'b0) q.push_back(rx);
                if (q.size() == DW + 3) begin
                    logic [DW-1:0] word;
                    int ones;
                    word = '0;
                    for (int i = 0; i < DW; i++) word[i] = q[1 + i];
                    ones    = $countones(word) + int'(q[DW + 1]);
                    m_data  = word;
                    m_perr  = (ones % 2) == 0;
                    m_ferr  = (q[DW + 2] == 1'b0);
                    m_valid = 1'b1;
                    if (m_perr || m_ferr) begin
                        if (m_cnt_a < 255) m_cnt_a++;
                        if (m_cnt_b < 3)   m_cnt_b++;
                    end
                    q.delete();
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        check("data_a",  32'(bus_a.data_out),   32'(m_data));
        check("valid_a", 32'(bus_a.valid),      32'(m_valid));
        check("perr_a",  32'(bus_a.parity_err), 32'(m_perr));
        check("ferr_a",  32'(bus_a.frame_err),  32'(m_ferr));
        check("busy_a",  32'(bus_a.busy),       32'(q.size() != 0));
        check("cnt_a",   32'(bus_a.err_count),  32'(m_cnt_a));
        check("valid_b", 32'(bus_b.valid),      32'(m_valid));
        check("cnt_b",   32'(bus_b.err_count),  32'(m_cnt_b));
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input logic en, input logic v);
        @(negedge clk);
        bit_en = en;
        rx     = v;
    endtask

    // gap idle clocks (rx random, must be ignored) followed by one strobe.
    task automatic strobe(input logic v, input int gap);
        for (int i = 0; i < gap; i++) step(1'b0, 1'($urandom));
        step(1'b1, v);
    endtask

    task automatic send_frame(input logic [DW-1:0] word, input logic p, input logic s,
                              input int first_gap, input int gap);
        strobe(1'b0, first_gap);
        for (int i = 0; i < DW; i++) strobe(word[i], gap);
        strobe(p, gap);
        strobe(s, gap);
    endtask

    // Step past the stop-bit edge and check the completed frame.
    task automatic expect_frame(input string tag, input logic [DW-1:0] d,
                                input logic pe, input logic fe, input int cnt_a);
        step(1'b0, 1'b1);
        check({tag, "_valid"}, 32'(bus_a.valid),      32'd1);
        check({tag, "_data"},  32'(bus_a.data_out),   32'(d));
        check({tag, "_perr"},  32'(bus_a.parity_err), 32'(pe));
        check({tag, "_ferr"},  32'(bus_a.frame_err),  32'(fe));
        check({tag, "_cnt"},   32'(bus_a.err_count),  32'(cnt_a));
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) step(1'b0, 1'b1);
        rst = 1'b0;

        // Idle line with strobes never starts a frame.
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        check("idle_busy",  32'(bus_a.busy),      32'd0);
        check("idle_valid", 32'(bus_a.valid),     32'd0);
        check("idle_cnt",   32'(bus_a.err_count), 32'd0);

        // Directed frames with hand-computed results.
        send_frame(8'h55, 1'b1, 1'b1, 0, 0);
        expect_frame("f55", 8'h55, 1'b0, 1'b0, 0);
        send_frame(8'h07, 1'b1, 1'b1, 1, 0);
        expect_frame("f07", 8'h07, 1'b1, 1'b0, 1);
        send_frame(8'hA3, 1'b1, 1'b0, 0, 1);
        expect_frame("fA3", 8'hA3, 1'b0, 1'b1, 2);

        // Strobe every 3rd clock, second frame starts on the next strobe.
        send_frame(8'hFF, 1'b1, 1'b1, 2, 2);
        expect_frame("fFF", 8'hFF, 1'b0, 1'b0, 2);
        step(1'b0, 1'b0);
        check("fFF_pulse_width", 32'(bus_a.valid), 32'd0);
        send_frame(8'h00, 1'b1, 1'b1, 0, 2);
        expect_frame("f00", 8'h00, 1'b0, 1'b0, 2);
        step(1'b0, 1'b1);
        check("f00_pulse_width", 32'(bus_a.valid), 32'd0);

        // Randomised frames, gaps and idle strobes.
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) strobe(1'b1, $urandom_range(0, 2));
            send_frame(8'($urandom), 1'($urandom), ($urandom_range(0, 4) != 0),
                       $urandom_range(0, 3), $urandom_range(0, 3));
        end
        repeat (3) step(1'b0, 1'b1);

        // Leave non-zero state behind, then abort a frame with reset.
        send_frame(8'h07, 1'b1, 1'b1, 0, 0);
        step(1'b0, 1'b1);
        strobe(1'b0, 0);
        for (int i = 0; i < 4; i++) strobe(1'($urandom_range(0, 1) == 1 ? 8'h3C >> i : 8'h3C >> i), 0);
        step(1'b0, 1'b1);
        check("pre_rst_busy", 32'(bus_a.busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_busy",  32'(bus_a.busy),       32'd0);
        check("rst_data",  32'(bus_a.data_out),   32'd0);
        check("rst_valid", 32'(bus_a.valid),      32'd0);
        check("rst_perr",  32'(bus_a.parity_err), 32'd0);
        check("rst_ferr",  32'(bus_a.frame_err),  32'd0);
        check("rst_cnt",   32'(bus_a.err_count),  32'd0);
        repeat (2) step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        rst = 1'b0;
        repeat (3) step(1'b0, 1'b1);
        send_frame(8'h3C, 1'b1, 1'b1, 0, 1);
        expect_frame("f3C", 8'h3C, 1'b0, 1'b0, 0);

        // Bad parity five times: 2-bit counter saturates at 3.
        for (int k = 0; k < 5; k++) begin
            send_frame(8'h07, 1'b1, 1'b1, 0, 0);
            step(1'b0, 1'b1);
            check("sat_b", 32'(bus_b.err_count), (k < 3) ? 32'(k + 1) : 32'd3);
            check("sat_a", 32'(bus_a.err_count), 32'(k + 1));
        end

        repeat (3) step(1'b0, 1'b1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/odd_parity_frame_checker.md
Name: odd_parity_frame_checker

Overview:
- Receive-side checker for odd-parity serial frames. Our odd parity generators produce the parity bit so that the data bits plus the parity bit contain an odd number of ones.
- Deserialises one frame: start bit, DATA_W data bits sent LSB first, one parity bit, one stop bit.
- Reports the recovered word, parity and framing status, and a saturating error count.
- Sits between the bit-timing logic, which supplies a per-bit sample strobe, and the consuming datapath.

Parameters:
- DATA_W, 8, number of data bits per frame (legal range 1..16).
- CNT_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- bit_en  input  1  sample strobe. The rx line is sampled only on cycles where bit_en=1.
- rx  input  1  serial line. Idle level is 1.
- data_out  output  DATA_W  last received data word.
- valid  output  1  one-cycle pulse: a frame has completed.
- parity_err  output  1  status of the last completed frame: odd parity violated.
- frame_err  output  1  status of the last completed frame: stop bit was 0.
- busy  output  1  high while a frame is being received (any state except IDLE).
- err_count  output  CNT_W  number of frames with parity_err or frame_err; saturates at all-ones.

Behaviour:
- Reset (async, rst=1): state=IDLE, bit counter=0, shift register=0. Outputs: data_out=0, valid=0, parity_err=0, frame_err=0, busy=0, err_count=0.
- Reset asserted mid-frame aborts the frame immediately: no valid pulse, no counter update.
- All state changes happen only on cycles where bit_en=1, except that valid deasserts on the next cycle regardless of bit_en.
- FSM:
  - IDLE: on bit_en with rx=0 (start bit) -> DATA, clear bit counter. rx=1 stays in IDLE.
  - DATA: on each bit_en, shift rx into the shift register at the MSB side (LSB-first reconstruction) and increment the counter. When the DATA_W-th bit is captured -> PARITY.
  - PARITY: on bit_en, capture rx as parity bit p -> STOP.
  - STOP: on bit_en, sample the stop bit s and -> IDLE. At this same clock edge:
    - data_out <= assembled word;
    - parity_err <= ~(^word ^ p), i.e. error when the total number of ones is even;
    - frame_err <= ~s;
    - valid <= 1 for exactly one cycle.
- Latency: valid rises on the clock edge at which the stop-bit strobe is sampled, and is visible for the following cycle.
- Frame timing: back-to-back frames are allowed. A start bit on the very next bit_en after the stop bit is accepted, because the FSM is already in IDLE.
- A frame is completed and flagged even on a framing error; there is no resynchronisation hunt.
- data_out, parity_err and frame_err hold their values until the next completed frame.
- err_count increments by 1 at the frame-completion edge if parity_err or frame_err is set for that frame; one frame counts at most once even when both errors are set. Once it reaches 2^CNT_W-1 it holds.
- bit_en=0 for any number of cycles freezes state; no timeout.
- busy=1 in DATA, PARITY and STOP; busy=0 in IDLE.

Test Plan:
- Reset, then rx=1 with bit_en=1 for 20 strobes -> state stays IDLE; busy=0, valid=0, err_count=0.
- Frame 0, 0x55 LSB first, p=1, s=1 (DATA_W=8) -> one valid pulse; data_out=0x55, parity_err=0, frame_err=0, err_count=0.
- Frame 0, 0x07, p=1, s=1 (total ones = 4, even) -> data_out=0x07, parity_err=1, frame_err=0, err_count=1. Then send 0xA3, p=1, s=0 -> parity_err=0, frame_err=1, err_count=2.
- Frame 0xFF, p=1, s=1, with bit_en pulsed every 3rd clock and a back-to-back second frame 0x00, p=1 -> two valid pulses, each exactly 1 clock wide; both frames have parity_err=0; data_out=0xFF then 0x00.
- Assert rst after 4 data bits of frame 0x3C -> all outputs 0 immediately (asynchronously); no valid pulse. A following clean frame 0x3C, p=1 -> data_out=0x3C, no errors.
- CNT_W=2: send 5 frames with bad parity -> err_count reads 1, 2, 3, 3, 3.
